if_id_fetch_queue: RTL and testbench

//   Decoupling queue between the program counter / instruction-memory fetch and the

---
 rtl/if_id_fetch_queue.sv | 92 +++++++++
 tb/tb_if_id_fetch_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_queue.sv
// Fetch-to-decode decoupling FIFO: show-ahead circular buffer of {PC, instruction}
// pairs with redirect flush. When the queue is empty, decode sees a NOP bubble.
module if_id_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [63:0]                pc_in,
  input  logic [31:0]                instr_in,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [63:0]                pc_out,
  output logic [31:0]                instr_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            push, pop;

  // in_ready depends only on registered occupancy, so a full queue refuses
  // a push even when decode pops in the same cycle.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_ready & out_valid;
  assign count     = count_q;

  always_comb begin
    pc_out    = 64'd0;
    instr_out = NOP_INSTR;
    if (out_valid) begin
      pc_out    = mem_q[rd_ptr_q].pc;
      instr_out = mem_q[rd_ptr_q].instr;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q].pc    <= pc_in;
      mem_q[wr_ptr_q].instr <= instr_in;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Randomized and directed bench for if_id_fetch_queue against a queue-based model.
module tb_if_id_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, in_ready, out_valid;
  logic [63:0] pc_in, pc_out;
  logic [31:0] instr_in, instr_out;
  logic [2:0]  count;

  if_id_fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .pc_in(pc_in), .instr_in(instr_in), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .pc_out(pc_out),
    .instr_out(instr_out), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t mq[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int sz = mq.size();
    chk("count", 64'(count), 64'(sz));
    chk("out_valid", 64'(out_valid), 64'(sz != 0));
    chk("in_ready", 64'(in_ready), 64'(sz != DEPTH));
    chk("pc_out", pc_out, (sz != 0) ? mq[0].pc : 64'd0);
    chk("instr_out", 64'(instr_out), 64'((sz != 0) ? mq[0].ins : NOP));
  endtask

  // Called at a negedge: drive inputs, let one rising edge happen, update model, check.
  task automatic step(input logic fl, input logic iv, input logic orr,
                      input logic [63:0] pc, input logic [31:0] ins);
    bit do_push, do_pop;
    ent_t e;
    flush = fl; in_valid = iv; out_ready = orr; pc_in = pc; instr_in = ins;
    do_push = iv && (mq.size() != DEPTH);
    do_pop  = orr && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc = pc; e.ins = ins;
        mq.push_back(e);
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 0; pc_in = '0; instr_in = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst instr_out", 64'(instr_out), 64'h13);
    chk("rst pc_out", pc_out, 64'd0);
    chk("rst count", 64'(count), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // pass-through: each push visible one cycle later, occupancy stays at one
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 64'(4 * i), 32'hA000_0000 + 32'(i));
      chk("pass pc_out", pc_out, 64'(4 * i));
      chk("pass count", 64'(count), 64'd1);
    end
    step(0, 0, 1, 0, 0);

    // fill past capacity: fifth push refused
    for (int i = 0; i < 5; i++) step(0, 1, 0, 64'h100 + 64'(4 * i), 32'hB000_0000 + 32'(i));
    chk("fill count", 64'(count), 64'd4);
    chk("fill in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain pc_out", pc_out, 64'h100 + 64'(4 * i));
      step(0, 0, 1, 0, 0);
    end
    chk("drain empty", 64'(out_valid), 64'd0);

    // wrap: hold occupancy at two while pointers circle the buffer
    step(0, 1, 0, 64'h200, 32'h1);
    step(0, 1, 0, 64'h204, 32'h2);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 64'h208 + 64'(4 * i), 32'h3 + 32'(i));
    chk("wrap count", 64'(count), 64'd2);
    chk("wrap pc_out", pc_out, 64'h218);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // flush beats a concurrent push and pop
    for (int i = 0; i < 3; i++) step(0, 1, 0, 64'h300 + 64'(4 * i), 32'hC0 + 32'(i));
    step(1, 1, 1, 64'h3FC, 32'hDEAD);
    chk("flush count", 64'(count), 64'd0);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush instr", 64'(instr_out), 64'h13);

    // async reset between edges
    step(0, 1, 0, 64'h400, 32'h11);
    step(0, 1, 0, 64'h404, 32'h12);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk("async count", 64'(count), 64'd0);
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async pc_out", pc_out, 64'd0);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_model();

    // random traffic in phases of varying pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic fl, iv, orr;
        fl  = ($urandom_range(0, 31) == 0);
        iv  = ($urandom_range(0, 3) < (ph == 1 ? 3 : 2));
        orr = ($urandom_range(0, 3) < (ph == 2 ? 3 : (ph == 1 ? 1 : 2)));
        step(fl, iv, orr, {$urandom, $urandom}, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule
